slicel_cfg_loader: RTL and testbench

Configuration loader directly upstream of the standard logic slice. It accepts the slice bitstream as a stream of `WORD_W`-bit words over a valid/ready handshake and assembles them into a shadow register. It then presents the complete slice configuration (LUT configs, inter-LUT mux config, carry-chain enable) on stable output registers and pulses `cen` for exactly one `cclk` cycle, so the slice captures the new configuration atomically.

---
 rtl/slicel_cfg_loader.sv | 98 +++++++++
 tb/tb_slicel_cfg_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/slicel_cfg_loader.sv
// Streams the logic-slice bitstream in WORD_W-bit words, assembles it in a shadow
// register and commits it atomically to the slice config outputs with a one-cycle cen.
module slicel_cfg_loader #(
  parameter  int S_XX_BASE    = 4,
  parameter  int NUM_LUTS     = 4,
  parameter  int WORD_W       = 8,
  localparam int SXX_CFG_SIZE = 2 * 2**S_XX_BASE + 1,
  localparam int MUX_LVLS     = $clog2(NUM_LUTS),
  localparam int LUT_BITS     = SXX_CFG_SIZE * NUM_LUTS,
  localparam int CFG_BITS     = LUT_BITS + MUX_LVLS + 1,
  localparam int NUM_WORDS    = (CFG_BITS + WORD_W - 1) / WORD_W,
  localparam int CNT_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LUT_BITS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0] inter_lut_mux_config,
  output logic                config_use_cc,
  output logic                cen,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic                accept;
  logic                last_word;

  // A start during LOAD wins over a concurrent handshake, so the word is refused.
  assign in_ready  = (state_q == ST_LOAD) && !start;
  assign accept    = in_ready && in_valid;
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (accept) begin
          // Bits of the final word beyond CFG_BITS have no home and are dropped.
          for (int i = 0; i < CFG_BITS; i++) begin
            if ((i / WORD_W) == int'(cnt_q)) shadow_d[i] = in_data[i % WORD_W];
          end
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            cfg_d   = shadow_d;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
    end
  end

  assign luts_config_in       = cfg_q[LUT_BITS-1:0];
  assign inter_lut_mux_config = cfg_q[LUT_BITS +: MUX_LVLS];
  assign config_use_cc        = cfg_q[CFG_BITS-1];
  assign cen                  = (state_q == ST_COMMIT);
  assign busy                 = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
  assign done                 = (state_q == ST_DONE);

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Randomized bench for slicel_cfg_loader against a word-queue reference model.
module tb_slicel_cfg_loader;
  localparam int NW = 17;
  localparam int CB = 135;
  localparam int LB = 132;

  logic          cclk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, config_use_cc, cen, busy, done;
  logic [LB-1:0] luts_config_in;
  logic [1:0]    inter_lut_mux_config;

  slicel_cfg_loader dut (
    .cclk(cclk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .luts_config_in(luts_config_in),
    .inter_lut_mux_config(inter_lut_mux_config), .config_use_cc(config_use_cc),
    .cen(cen), .busy(busy), .done(done)
  );

  always #5 cclk = ~cclk;

  // Reference model: a load collects words in a queue; the 17th word commits them.
  logic          m_load, m_cen, m_done;
  logic [7:0]    m_q[$];
  logic [CB-1:0] m_cfg;
  logic [7:0]    w[NW];
  int            n_cmp, n_bad, cen_seen;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic v, input logic [7:0] d, input logic r);
    @(negedge cclk);
    rst = r; start = st; in_valid = v; in_data = d;
    #1;
    chk("in_ready", in_ready, m_load && !st);
    chk("cen", cen, m_cen);
    chk("busy", busy, m_load || m_cen);
    chk("done", done, m_done);
    chk("luts", luts_config_in, m_cfg[LB-1:0]);
    chk("mux", inter_lut_mux_config, m_cfg[LB +: 2]);
    chk("use_cc", config_use_cc, m_cfg[CB-1]);
    if (cen) cen_seen++;
    @(posedge cclk);
    if (r) begin
      m_load = 0; m_cen = 0; m_done = 0; m_cfg = '0; m_q.delete();
    end else if (m_cen) begin
      m_cen = 0; m_done = 1;
    end else if (m_load) begin
      if (st) m_q.delete();
      else if (v) begin
        m_q.push_back(d);
        if (m_q.size() == NW) begin
          for (int k = 0; k < NW; k++)
            for (int b = 0; b < 8; b++)
              if (k * 8 + b < CB) m_cfg[k * 8 + b] = m_q[k][b];
          m_q.delete();
          m_load = 0; m_cen = 1;
        end
      end
    end else if (st) begin
      m_load = 1; m_done = 0; m_q.delete();
    end
  endtask

  task automatic feed(input int n, input int gap_pct);
    int i = 0;
    int guard = 0;
    logic v;
    while (i < n && guard < 5000) begin
      v = ($urandom_range(99) >= gap_pct);
      step(1'b0, v, v ? w[i] : 8'($urandom()), 1'b0);
      if (v) i++;
      guard++;
    end
    if (guard >= 5000) chk("feed_timeout", 1, 0);
  endtask

  task automatic load(input int gap_pct);
    step(1'b1, 1'b0, 8'($urandom()), 1'b0);
    feed(NW, gap_pct);
    step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom()), 1'b0);
    repeat (3) step(1'b0, 1'($urandom_range(1)), 8'($urandom()), 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cen_seen = 0;
    m_load = 0; m_cen = 0; m_done = 0; m_cfg = '0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge cclk);

    // Reset, then valid without start is ignored
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (5) step(1'b0, 1'b1, 8'($urandom()), 1'b0);
    chk("idle_ready", in_ready, 0);
    chk("idle_cfg", luts_config_in, 0);

    // Gap-free incrementing load
    for (int k = 0; k < NW; k++) w[k] = 8'(k);
    cen_seen = 0;
    load(0);
    chk("inc_cen_once", cen_seen, 1);
    chk("inc_byte0", luts_config_in[7:0], 8'h00);
    chk("inc_byte1", luts_config_in[15:8], 8'h01);
    chk("inc_byte15", luts_config_in[127:120], 8'h0F);
    chk("inc_use_cc", config_use_cc, 0);
    chk("inc_done", done, 1);

    // Only the final word set: high bits land in cc/mux/top LUT nibble
    for (int k = 0; k < NW; k++) w[k] = 8'h00;
    w[NW-1] = 8'hFF;
    cen_seen = 0;
    load(0);
    chk("ff_cen_once", cen_seen, 1);
    chk("ff_use_cc", config_use_cc, 1);
    chk("ff_mux", inter_lut_mux_config, 2'b11);
    chk("ff_top_nib", luts_config_in[131:128], 4'hF);
    chk("ff_low", luts_config_in[127:0], 0);

    // Stalled incrementing load
    for (int k = 0; k < NW; k++) w[k] = 8'(k);
    cen_seen = 0;
    load(30);
    chk("stall_cen_once", cen_seen, 1);
    for (int k = 0; k < 16; k++) chk("stall_byte", luts_config_in[k*8 +: 8], 8'(k));
    chk("stall_top_nib", luts_config_in[131:128], 4'h0);
    chk("stall_use_cc", config_use_cc, 0);

    // Abort after 9 words, then a full 0xA5 load
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom());
    cen_seen = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    feed(9, 20);
    chk("abort_no_cen", cen_seen, 0);
    for (int k = 0; k < NW; k++) w[k] = 8'hA5;
    load(10);
    chk("abort_cen_once", cen_seen, 1);
    for (int k = 0; k < 16; k++) chk("abort_byte", luts_config_in[k*8 +: 8], 8'hA5);
    chk("abort_top_nib", luts_config_in[131:128], 4'h5);
    chk("abort_mux", inter_lut_mux_config, 2'b10);
    chk("abort_use_cc", config_use_cc, 0);

    // Reset after 10 words
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom());
    cen_seen = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    feed(10, 20);
    step(1'b0, 1'b1, 8'($urandom()), 1'b1);
    repeat (4) step(1'b0, 1'b1, 8'($urandom()), 1'b0);
    chk("rst_no_cen", cen_seen, 0);
    chk("rst_luts", luts_config_in, 0);
    chk("rst_busy", busy, 0);
    load(20);
    chk("rst_reload_cen", cen_seen, 1);

    // Random loads with random gap rates and occasional aborts
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NW; k++) w[k] = 8'($urandom());
      cen_seen = 0;
      if ($urandom_range(1) == 1) begin
        step(1'b1, 1'b0, 8'h00, 1'b0);
        feed($urandom_range(1, NW - 1), 25);
      end
      load($urandom_range(0, 50));
      chk("rand_cen_once", cen_seen, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
